// File: rtl/sdpram_pkg.sv
// Shared types and width helpers for the SDP RAM read-side stream engine.
package sdpram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    localparam int unsigned RD_LATENCY = 2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo32.sv
// 32-bit synchronous FIFO; head entry is read straight from storage flops,
// so a word pushed in one cycle is visible at the output in the next.
module sync_fifo32
    import sdpram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [31:0]                    data_i,
    input  logic                           pop_i,
    output logic [31:0]                    data_o,
    output logic [cnt_width(DEPTH)-1:0]    count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/sdpram32_stream_reader.sv
// Burst read engine for the 32-bit SDP block RAM: issues credit-limited reads
// around write-port collisions and streams the words out with last marking.
module sdpram32_stream_reader
    import sdpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    input  logic                  mem_write_active,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_read_enable,
    input  logic [31:0]           mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last
);

    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned IW = $clog2(RD_LATENCY + 1);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         remaining_q, remaining_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         out_cnt_q, out_cnt_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;

    logic [IW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [SW-1:0]         occupancy;
    logic                  credit_ok, issue, out_hs;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IW'(vld_q[i]);
        end
    end

    // Words already buffered plus reads still in the RAM pipeline must fit the FIFO.
    assign occupancy = SW'(fifo_count) + SW'(inflight);
    assign credit_ok = !fifo_full && (occupancy < SW'(FIFO_DEPTH));
    assign issue     = (state_q == RUN) && !mem_write_active
                       && (remaining_q != '0) && credit_ok;

    assign vld_d  = RD_LATENCY'({vld_q, issue});
    assign out_hs = out_valid && out_ready;

    sync_fifo32 #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (vld_q[RD_LATENCY-1]),
        .data_i  (mem_read_data),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid       = !fifo_empty;
    assign out_last        = out_valid && (out_cnt_q == len_q - LW'(1));
    assign mem_read_enable = issue;
    assign mem_read_addr   = addr_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        out_cnt_d   = out_cnt_q;
        if (out_hs) out_cnt_d = out_cnt_q + LW'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = length;
                    len_d       = length;
                    out_cnt_d   = '0;
                    state_d     = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LW'(1);
                    if (remaining_q == LW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) && fifo_empty && (out_cnt_q == len_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            out_cnt_q   <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            out_cnt_q   <= out_cnt_d;
            vld_q       <= vld_d;
        end
    end

endmodule

// File: tb/tb_sdpram32_stream_reader.sv
// Scoreboard bench for sdpram32_stream_reader with a 2-cycle RAM read model.
module tb_sdpram32_stream_reader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done;
    logic          mem_write_active;
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_enable;
    logic [31:0]   mem_read_data;
    logic          out_valid, out_ready, out_last;
    logic [31:0]   out_data;

    always #5 clk = ~clk;

    sdpram32_stream_reader #(
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_write_active (mem_write_active),
        .mem_read_addr    (mem_read_addr),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last)
    );

    // RAM model: reads ignored in write cycles, data two cycles after an effective read.
    logic [31:0] tb_mem [1024];
    logic [31:0] p1, p2;
    initial for (int i = 0; i < 1024; i++) tb_mem[i] = 32'hA500_0000 + 32'(i);
    always @(posedge clk) begin
        if (mem_read_enable && !mem_write_active) p1 <= tb_mem[mem_read_addr];
        p2 <= p1;
    end
    assign mem_read_data = p2;

    typedef struct {
        string           nm;
        longint unsigned act;
        longint unsigned exp;
    } chk_t;

    chk_t        cq[$];
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          done_seen = 0;
    int          ready_mode = 0;
    int          collide_mode = 0;

    function automatic void post(input string nm, input longint unsigned a, input longint unsigned e);
        chk_t c;
        c.nm  = nm;
        c.act = a;
        c.exp = e;
        cq.push_back(c);
    endfunction

    // Monitor: owns all comparisons and the pass/fail counters.
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;
    always @(negedge clk) begin : mon
        chk_t        c;
        logic [32:0] e;
        while (cq.size() != 0) begin
            c = cq.pop_front();
            checks++;
            if (c.act != c.exp) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", c.nm, c.act, c.exp);
            end
        end
        if (!reset) begin
            if (mem_read_enable) begin
                checks++;
                if (mem_write_active) begin
                    errors++;
                    $display("FAIL read_during_write addr=%0h write_active=1 required=0", mem_read_addr);
                end
            end
            if (hold_v) begin
                checks++;
                if (!out_valid || out_data !== hold_d || out_last !== hold_l) begin
                    errors++;
                    $display("FAIL stream_hold valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                             out_valid, out_data, out_last, hold_d, hold_l);
                end
            end
            if (out_valid && out_ready) begin
                hs_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word data=%h last=%0b required no word", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL stream_word data=%h last=%0b required data=%h last=%0b",
                                 out_data, out_last, e[31:0], e[32]);
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        mem_write_active = (collide_mode != 0) ? ~mem_write_active : 1'b0;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
        if (done) done_seen++;
    endtask

    task automatic start_cmd(input logic [AW-1:0] a, input int n, input bit expect_words);
        logic [AW-1:0] ad;
        start_addr = a;
        length     = (AW+1)'(n);
        start      = 1'b1;
        done_seen  = 0;
        if (expect_words) begin
            for (int i = 0; i < n; i++) begin
                ad = a + AW'(i);
                exp_q.push_back({(i == n - 1), 32'hA500_0000 + {22'd0, ad}});
            end
        end
        step();
        start = 1'b0;
    endtask

    task automatic finish_burst(input int lim);
        int n;
        n = 0;
        while (done_seen == 0 && n < lim) begin
            step();
            n++;
        end
        post("done_reached", done_seen != 0, 1);
        step();
        post("busy_after_done", busy, 0);
        repeat (3) step();
        post("done_pulse_count", done_seen, 1);
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            step();
            n++;
        end
        post("words_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0;
        mem_write_active = 1'b0; out_ready = 1'b1;
        step(); step();
        post("rst_busy", busy, 0);
        post("rst_done", done, 0);
        post("rst_re", mem_read_enable, 0);
        post("rst_raddr", mem_read_addr, 0);
        post("rst_valid", out_valid, 0);
        post("rst_last", out_last, 0);
        post("rst_data", out_data, 0);
        reset = 1'b0;
        step();

        // Basic burst: latency and gap-free streaming
        base = hs_count;
        start_cmd(10'h010, 8, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        post("first_valid_latency", n, 4);
        for (int k = 0; k < 8; k++) begin
            post("basic_no_gap", out_valid, 1);
            post("basic_last_pos", out_last, (k == 7));
            step();
        end
        finish_burst(50);
        post("basic_word_count", hs_count - base, 8);

        // Wrap past the top of memory
        base = hs_count;
        start_cmd(10'h3FE, 4, 1);
        finish_burst(50);
        post("wrap_word_count", hs_count - base, 4);

        // Backpressure: toggling ready, then fully stalled
        base = hs_count;
        ready_mode = 1;
        start_cmd(10'h080, 16, 1);
        repeat (16) step();
        ready_mode = 2;
        repeat (20) step();
        post("stall_read_enable", mem_read_enable, 0);
        post("stall_out_valid", out_valid, 1);
        ready_mode = 0;
        finish_burst(300);
        post("bp_word_count", hs_count - base, 16);

        // Write collisions on alternate cycles
        base = hs_count;
        collide_mode = 1;
        start_cmd(10'h0C0, 6, 1);
        finish_burst(200);
        collide_mode = 0;
        post("collide_word_count", hs_count - base, 6);

        // Zero length
        base = hs_count;
        start_cmd(10'h000, 0, 1);
        post("zero_len_done_cycle1", done_seen, 1);
        post("zero_len_no_valid", out_valid, 0);
        finish_burst(10);
        post("zero_len_word_count", hs_count - base, 0);

        // Start while busy is ignored
        base = hs_count;
        start_cmd(10'h020, 4, 1);
        step();
        post("busy_during_burst", busy, 1);
        start_addr = 10'h100;
        length     = 11'd4;
        start      = 1'b1;
        step();
        start = 1'b0;
        finish_burst(100);
        post("busy_start_word_count", hs_count - base, 4);

        // Reset mid-burst
        base = hs_count;
        start_cmd(10'h040, 10, 1);
        n = 0;
        while (hs_count - base < 3 && n < 100) begin
            step();
            n++;
        end
        post("three_words_before_reset", (hs_count - base) >= 3, 1);
        reset = 1'b1;
        #1;
        post("mid_rst_busy", busy, 0);
        post("mid_rst_done", done, 0);
        post("mid_rst_re", mem_read_enable, 0);
        post("mid_rst_raddr", mem_read_addr, 0);
        post("mid_rst_valid", out_valid, 0);
        post("mid_rst_last", out_last, 0);
        post("mid_rst_data", out_data, 0);
        exp_q.delete();
        step(); step();
        reset = 1'b0;
        step();
        base = hs_count;
        start_cmd(10'h050, 2, 1);
        finish_burst(50);
        post("post_reset_word_count", hs_count - base, 2);

        // Full-memory burst
        base = hs_count;
        start_cmd(10'h200, 1024, 1);
        finish_burst(3000);
        post("full_word_count", hs_count - base, 1024);
        post("full_addr_wrap", mem_read_addr, 10'h200);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
